gshare_predictor: RTL and testbench

//  Parametrised direction predictor: table of 2^IDX_W saturating counters, indexed by PC
//  (bimodal mode) or by PC XOR global history (gshare mode). Sits beside fetch.

---
 rtl/gshare_predictor_pkg.sv | 21 ++
 rtl/gshare_predictor_counter_table.sv | 43 ++++
 rtl/gshare_predictor.sv | 97 +++++++++
 tb/tb_gshare_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared defaults and the saturating-counter step used by the gshare predictor.
package predictor_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int IDX_W_DEF = 6;
    localparam int CTR_W_DEF = 2;
    localparam int GHR_W_DEF = 6;

    // Counter step for any counter width up to 31 bits; the caller truncates the result.
    function automatic logic [31:0] sat_next(input logic [31:0] ctr, input logic taken,
                                             input int unsigned ctr_w);
        logic [31:0] max_val;
        max_val = (32'd1 << ctr_w) - 32'd1;
        if (taken) begin
            return (ctr < max_val) ? ctr + 32'd1 : ctr;
        end else begin
            return (ctr > 32'd0) ? ctr - 32'd1 : ctr;
        end
    endfunction

endpackage

// File: rtl/gshare_predictor_counter_table.sv
// Flop array of saturating counters: one training write port, one read port that
// sees a same-cycle write to the same entry.
module pred_counter_table
    import predictor_pkg::*;
#(
    parameter int IDX_W    = IDX_W_DEF,
    parameter int CTR_W    = CTR_W_DEF,
    parameter int CTR_INIT = (1 << CTR_W_DEF) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][CTR_W-1:0] ctr_all;
    logic [CTR_W-1:0]            wr_next;

    assign wr_next = CTR_W'(sat_next(32'(ctr_all[wr_idx]), wr_taken, CTR_W));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [CTR_W-1:0] ctr_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg <= CTR_W'(CTR_INIT);
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ctr_reg <= wr_next;
                end
            end
            assign ctr_all[gi] = ctr_reg;
        end
    endgenerate

    // Bypass so a request colliding with a training write predicts from the new value.
    assign rd_ctr = (wr_en && (wr_idx == rd_idx)) ? wr_next : ctr_all[rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal direction predictor: index hash, global history and registered
// prediction outputs around the counter table.
module gshare_predictor
    import predictor_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int CTR_W    = CTR_W_DEF,
    parameter int GHR_W    = GHR_W_DEF,
    parameter int HIST_EN  = 1,
    parameter int CTR_INIT = (1 << CTR_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    output logic [GHR_W-1:0] ghr_out
);

    generate
        if ((GHR_W > IDX_W) || (GHR_W < 1) || (CTR_W < 1)) begin : g_bad_params
            $error("gshare_predictor: need 1 <= GHR_W <= IDX_W and CTR_W >= 1");
        end
    endgenerate

    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_next;
    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] req_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             pred_valid_reg;
    logic             pred_taken_reg;
    logic [IDX_W-1:0] pred_index_reg;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

    assign hist_ext = (HIST_EN != 0) ? IDX_W'(ghr_reg) : '0;
    assign req_idx  = req_pc[IDX_W+1:2] ^ hist_ext;

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_next = upd_taken;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr_reg[GHR_W-2:0], upd_taken};
        end
    endgenerate

    pred_counter_table #(
        .IDX_W   (IDX_W),
        .CTR_W   (CTR_W),
        .CTR_INIT(CTR_INIT)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (upd_valid),
        .wr_idx  (upd_index),
        .wr_taken(upd_taken),
        .rd_idx  (req_idx),
        .rd_ctr  (rd_ctr)
    );

    // History only moves on resolved branches, never on prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg <= '0;
        end else if (upd_valid) begin
            ghr_reg <= ghr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_index_reg <= '0;
        end else begin
            pred_valid_reg <= req_valid;
            if (req_valid) begin
                pred_taken_reg <= rd_ctr[CTR_W-1];
                pred_index_reg <= req_idx;
            end
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_index = pred_index_reg;
    assign ghr_out    = ghr_reg;

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench: a gshare instance (2-bit counters) and a bimodal instance
// (3-bit counters, init 4) share stimulus and are checked against a table model.
module tb_gshare_predictor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [31:0] req_pc;
    logic       upd_valid;
    logic [5:0] upd_index;
    logic       upd_taken;

    logic       pv0, pt0, pv1, pt1;
    logic [5:0] pi0, pi1, gh0, gh1;

    always #5 clk = ~clk;

    gshare_predictor #(.PC_W(32), .IDX_W(6), .CTR_W(2), .GHR_W(6), .HIST_EN(1), .CTR_INIT(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv0), .pred_taken(pt0), .pred_index(pi0),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .ghr_out(gh0));

    gshare_predictor #(.PC_W(32), .IDX_W(6), .CTR_W(3), .GHR_W(6), .HIST_EN(0), .CTR_INIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv1), .pred_taken(pt1), .pred_index(pi1),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .ghr_out(gh1));

    typedef struct {
        int idx;
        int taken;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int m_ctr[2][64];
    int m_ghr;

    function automatic int ctr_w(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int model_idx(input int k, input logic [31:0] pc);
        int base;
        base = int'((pc >> 2) & 32'h3f);
        return (k == 0) ? (base ^ m_ghr) : base;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[0][i] = 3;
            m_ctr[1][i] = 4;
        end
        m_ghr = 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model applies training before reading so a
    // same-cycle collision predicts from the trained value.
    task automatic drive(input int rv, input logic [31:0] pc, input int uv, input int ui, input int ut);
        int idx[2];
        int maxv;
        exp_t e;
        @(negedge clk);
        req_valid = rv[0];
        req_pc    = pc;
        upd_valid = uv[0];
        upd_index = ui[5:0];
        upd_taken = ut[0];
        for (int k = 0; k < 2; k++) idx[k] = model_idx(k, pc);
        if (uv != 0) begin
            for (int k = 0; k < 2; k++) begin
                maxv = (1 << ctr_w(k)) - 1;
                if (ut != 0 && m_ctr[k][ui] < maxv) m_ctr[k][ui]++;
                else if (ut == 0 && m_ctr[k][ui] > 0) m_ctr[k][ui]--;
            end
        end
        if (rv != 0) begin
            e.idx = idx[0]; e.taken = (m_ctr[0][idx[0]] >> 1) & 1; q0.push_back(e);
            e.idx = idx[1]; e.taken = (m_ctr[1][idx[1]] >> 2) & 1; q1.push_back(e);
        end
        if (uv != 0) m_ghr = ((m_ghr << 1) | (ut & 1)) & 63;
        if (rv != 0 || uv != 0)
            $display("txn t=%0t req=%0d pc=0x%08h upd=%0d uidx=0x%02h utaken=%0d", $time, rv, pc, uv, ui, ut);
    endtask

    // Reset is asserted between clock edges so its asynchronous effect is visible at once.
    task automatic reset_dut();
        @(negedge clk);
        req_valid = 1'b0;
        upd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_pred_valid0", int'(pv0), 0);
        check("rst_pred_valid1", int'(pv1), 0);
        check("rst_ghr0", int'(gh0), 0);
        check("rst_ghr1", int'(gh1), 0);
        check("rst_pred_taken0", int'(pt0), 0);
        check("rst_pred_index0", int'(pi0), 0);
        model_reset();
        q0.delete();
        q1.delete();
        $display("txn t=%0t reset", $time);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            check("ghr0", int'(gh0), m_ghr);
            check("ghr1", int'(gh1), m_ghr);
            if (pv0) begin
                if (q0.size() == 0) begin
                    check("unexpected_pred0", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("pred_index0", int'(pi0), e.idx);
                    check("pred_taken0", int'(pt0), e.taken);
                end
            end else if (q0.size() != 0) begin
                check("missing_pred0", 0, 1);
                void'(q0.pop_front());
            end
            if (pv1) begin
                if (q1.size() == 0) begin
                    check("unexpected_pred1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("pred_index1", int'(pi1), e.idx);
                    check("pred_taken1", int'(pt1), e.taken);
                end
            end else if (q1.size() != 0) begin
                check("missing_pred1", 0, 1);
                void'(q1.pop_front());
            end
        end
    end

    initial begin
        int ui;
        logic [31:0] pc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_dut();

        // First prediction from reset state, then saturation toward zero.
        drive(1, 32'h40, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 1, 6'h10, 0);
        drive(1, 32'h40, 0, 0, 0);
        drive(0, 32'h0, 1, 6'h10, 1);
        drive(0, 32'h0, 1, 6'h10, 1);
        drive(1, 32'h40, 0, 0, 0);

        // Same-cycle collision vs. neighbouring index.
        drive(1, 32'h40, 1, model_idx(0, 32'h40), 0);
        drive(1, 32'h40, 1, model_idx(0, 32'h40) ^ 1, 0);

        // History folding into the index.
        reset_dut();
        drive(0, 32'h0, 1, 6'h3f, 1);
        drive(0, 32'h0, 1, 6'h3f, 0);
        drive(0, 32'h0, 1, 6'h3f, 1);
        @(posedge clk);
        #2;
        check("ghr_after_101", int'(gh0), 6'h05);
        drive(1, 32'h40, 0, 0, 0);

        // Drive ctr[0x15] to zero, then reset with a prediction in flight.
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 6'h15, 0);
        drive(1, 32'h54, 0, 0, 0);
        reset_dut();
        drive(1, 32'h54, 0, 0, 0);

        // Counter walk on the 3-bit instance: up to saturation, then back across the MSB.
        for (int i = 0; i < 7; i++) drive(1, 32'h54, 1, 6'h15, 1);
        for (int i = 0; i < 5; i++) drive(1, 32'h54, 1, 6'h15, 0);

        for (int n = 0; n < 600; n++) begin
            pc = $urandom;
            case ($urandom_range(2))
                0:       ui = model_idx(0, pc);
                1:       ui = 16 + int'($urandom_range(7));
                default: ui = int'($urandom_range(63));
            endcase
            if ($urandom_range(149) == 0) reset_dut();
            drive(($urandom_range(3) != 0) ? 1 : 0, pc, int'($urandom_range(1)), ui, int'($urandom_range(1)));
        end

        drive(0, 32'h0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
